// File: rtl/tlp_pkg.sv
// Shared definitions for the egress TLP mux: bus widths, arbiter state encoding
// and the port identifier used to remember the last grant.
package tlp_pkg;

    localparam int DOUBLE_WORD    = 32;
    localparam int HEADER_SIZE    = 4 * DOUBLE_WORD;
    localparam int TLP_DATA_WIDTH = 8 * DOUBLE_WORD;

    // Arbiter states; kept as plain constants so older code can share them.
    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] BUSY_A = 2'd1;
    localparam logic [1:0] BUSY_B = 2'd2;

    typedef enum logic {
        PORT_A = 1'b0,
        PORT_B = 1'b1
    } port_e;

endpackage

// File: rtl/tlp_pipe_reg.sv
// One-deep valid/ready register slice carrying a TLP beat {data, hdr, sop, eop}.
// The header register only loads on sop beats and holds its value otherwise.
module tlp_pipe_reg
    import tlp_pkg::*;
#(
    parameter int DATA_W = TLP_DATA_WIDTH,
    parameter int HDR_W  = HEADER_SIZE
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic [HDR_W-1:0]  in_hdr,
    input  logic              in_sop,
    input  logic              in_eop,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [HDR_W-1:0]  out_hdr,
    output logic              out_sop,
    output logic              out_eop
);

    logic              valid_q, valid_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic [HDR_W-1:0]  hdr_q, hdr_d;
    logic              sop_q, sop_d;
    logic              eop_q, eop_d;
    logic              load;

    // The slot can take a new beat when empty or when its current beat leaves now.
    assign in_ready = !valid_q || out_ready;
    assign load     = in_valid && in_ready;

    // Next-state: load a new beat, drain the held beat, or hold everything stable.
    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        hdr_d   = hdr_q;
        sop_d   = sop_q;
        eop_d   = eop_q;
        if (load) begin
            valid_d = 1'b1;
            data_d  = in_data;
            sop_d   = in_sop;
            eop_d   = in_eop;
            if (in_sop) begin
                hdr_d = in_hdr;
            end
        end else if (out_ready) begin
            valid_d = 1'b0;
        end
    end

    // Slice registers; all cleared by reset so the egress bus starts at zero.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            data_q  <= '0;
            hdr_q   <= '0;
            sop_q   <= 1'b0;
            eop_q   <= 1'b0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
            hdr_q   <= hdr_d;
            sop_q   <= sop_d;
            eop_q   <= eop_d;
        end
    end

    assign out_valid = valid_q;
    assign out_data  = data_q;
    assign out_hdr   = hdr_q;
    assign out_sop   = sop_q;
    assign out_eop   = eop_q;

endmodule

// File: rtl/tlp_tx_mux.sv
// Egress TLP mux: round-robin arbitration between the completion stream (A) and
// the locally generated stream (B), switching only on packet boundaries, with
// orphan (sop-less) beats dropped while idle and the result sent through one
// register slice.
module tlp_tx_mux
    import tlp_pkg::*;
#(
    parameter int DOUBLE_WORD    = tlp_pkg::DOUBLE_WORD,
    parameter int HEADER_SIZE    = 4 * DOUBLE_WORD,
    parameter int TLP_DATA_WIDTH = 8 * DOUBLE_WORD
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [TLP_DATA_WIDTH-1:0] a_data,
    input  logic [HEADER_SIZE-1:0]    a_hdr,
    input  logic                      a_sop,
    input  logic                      a_eop,
    input  logic                      a_valid,
    output logic                      a_ready,
    input  logic [TLP_DATA_WIDTH-1:0] b_data,
    input  logic [HEADER_SIZE-1:0]    b_hdr,
    input  logic                      b_sop,
    input  logic                      b_eop,
    input  logic                      b_valid,
    output logic                      b_ready,
    output logic [TLP_DATA_WIDTH-1:0] out_data,
    output logic [HEADER_SIZE-1:0]    out_hdr,
    output logic                      out_sop,
    output logic                      out_eop,
    output logic                      out_valid,
    input  logic                      out_ready,
    input  logic                      enable,
    output logic                      err_orphan
);

    logic [1:0]                state_q, state_d;
    port_e                     last_q, last_d;
    logic                      err_q, err_d;

    logic                      slice_ready;
    logic                      cand_a, cand_b;
    logic                      orph_a, orph_b;
    logic                      grant_a, grant_b;
    logic                      sel_a, sel_b;
    logic                      fwd_valid;
    logic [TLP_DATA_WIDTH-1:0] fwd_data;
    logic [HEADER_SIZE-1:0]    fwd_hdr;
    logic                      fwd_sop, fwd_eop;
    logic                      fire;

    // Idle-time winner selection: a lone candidate wins, a tie goes to the port
    // that did not win last time.
    always_comb begin
        cand_a  = a_valid && a_sop;
        cand_b  = b_valid && b_sop;
        orph_a  = a_valid && !a_sop;
        orph_b  = b_valid && !b_sop;
        grant_a = 1'b0;
        grant_b = 1'b0;
        if (state_q == IDLE && enable) begin
            if (cand_a && cand_b) begin
                grant_a = (last_q == PORT_B);
                grant_b = (last_q == PORT_A);
            end else begin
                grant_a = cand_a;
                grant_b = cand_b;
            end
        end
    end

    // Route the owning port into the slice; orphans in IDLE are acked and dropped.
    always_comb begin
        sel_a     = (state_q == BUSY_A) || grant_a;
        sel_b     = (state_q == BUSY_B) || grant_b;
        a_ready   = sel_a ? slice_ready : (state_q == IDLE && orph_a);
        b_ready   = sel_b ? slice_ready : (state_q == IDLE && orph_b);
        fwd_valid = (sel_a && a_valid) || (sel_b && b_valid);
        fwd_data  = sel_b ? b_data : a_data;
        fwd_hdr   = sel_b ? b_hdr  : a_hdr;
        fwd_sop   = sel_b ? b_sop  : a_sop;
        fwd_eop   = sel_b ? b_eop  : a_eop;
        fire      = fwd_valid && slice_ready;
    end

    // Packet-boundary FSM: ownership is taken on the winning sop beat and
    // released on the eop beat transfer.
    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        err_d   = (state_q == IDLE) && (orph_a || orph_b);
        case (state_q)
            IDLE: begin
                if (fire) begin
                    last_d = sel_b ? PORT_B : PORT_A;
                    if (!fwd_eop) begin
                        state_d = sel_b ? BUSY_B : BUSY_A;
                    end
                end
            end
            BUSY_A, BUSY_B: begin
                if (fire && fwd_eop) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Control registers; last_grant resets to B so the first tie goes to A.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            last_q  <= PORT_B;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            err_q   <= err_d;
        end
    end

    assign err_orphan = err_q;

    tlp_pipe_reg #(
        .DATA_W (TLP_DATA_WIDTH),
        .HDR_W  (HEADER_SIZE)
    ) u_slice (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (fwd_valid),
        .in_ready  (slice_ready),
        .in_data   (fwd_data),
        .in_hdr    (fwd_hdr),
        .in_sop    (fwd_sop),
        .in_eop    (fwd_eop),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_hdr   (out_hdr),
        .out_sop   (out_sop),
        .out_eop   (out_eop)
    );

endmodule
